// File: rtl/mp_lut_loader.sv
// Coefficient load controller for the replicated MP LUT datapath: streams LUT
// words into the BRAM write port and holds DPD off while tables are rewritten.
module mp_lut_loader #(
  parameter int M           = 3,
  parameter int LUT_num     = M + 1,
  parameter int RESOLUTION  = 4096,
  parameter int MUTE_CYCLES = 16,
  parameter int ADDR_W      = $clog2(RESOLUTION) + $clog2(LUT_num) + 2
) (
  input  logic              AXI_clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [31:0]       s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic [31:0]       coeff_o,
  output logic [ADDR_W-1:0] coeff_addr_o,
  output logic              coeff_en_o,
  input  logic              wdpd_req_i,
  output logic              wdpd_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int N_WORDS = LUT_num * RESOLUTION;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N_WORDS - 1);
  localparam int MCNT_W = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
  localparam logic [MCNT_W-1:0] MUTE_LAST = MCNT_W'(MUTE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUTE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WORD_W-1:0]   r_word;
  logic [WORD_W-1:0]   w_word_next;
  logic [MCNT_W-1:0]   r_mute_cnt;
  logic [MCNT_W-1:0]   w_mute_cnt_next;
  logic                r_err;
  logic                w_err_next;
  logic                r_lut_valid;
  logic                w_lut_valid_next;
  logic                r_wdpd;
  logic                w_wdpd_next;
  logic [31:0]         r_coeff;
  logic [ADDR_W-1:0]   r_coeff_addr;
  logic                r_coeff_en;

  logic w_ready;
  logic w_hs;
  logic w_write;

  assign w_ready = (r_state == S_LOAD);
  assign w_hs    = s_valid_i && w_ready;
  // abort wins over a simultaneous handshake: that word is dropped
  assign w_write = w_hs && !abort_i;

  always_comb begin
    w_state_next     = r_state;
    w_word_next      = r_word;
    w_mute_cnt_next  = r_mute_cnt;
    w_err_next       = r_err;
    w_lut_valid_next = r_lut_valid;
    case (r_state)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          w_state_next     = S_MUTE;
          w_err_next       = 1'b0;
          w_lut_valid_next = 1'b0;
          w_word_next      = '0;
          w_mute_cnt_next  = '0;
        end
      end
      S_MUTE: begin
        if (abort_i) begin
          w_state_next     = S_IDLE;
          w_err_next       = 1'b1;
          w_lut_valid_next = 1'b0;
        end else if (r_mute_cnt == MUTE_LAST) begin
          w_state_next = S_LOAD;
        end else begin
          w_mute_cnt_next = r_mute_cnt + MCNT_W'(1);
        end
      end
      S_LOAD: begin
        if (abort_i) begin
          w_state_next     = S_IDLE;
          w_err_next       = 1'b1;
          w_lut_valid_next = 1'b0;
        end else if (w_hs) begin
          w_word_next = r_word + WORD_W'(1);
          if (s_last_i && (r_word == LAST_WORD)) begin
            w_state_next = S_DONE;
          end else if (s_last_i || (r_word == LAST_WORD)) begin
            // short or long frame; the offending word is still written
            w_state_next     = S_ERR;
            w_err_next       = 1'b1;
            w_lut_valid_next = 1'b0;
          end
        end
      end
      S_DONE: begin
        w_lut_valid_next = 1'b1;
        w_state_next     = S_IDLE;
      end
      S_ERR: begin
        w_lut_valid_next = 1'b0;
        w_state_next     = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // looking at next-state lets DPD re-enable on the first idle cycle after DONE
  assign w_wdpd_next = wdpd_req_i && (w_state_next == S_IDLE) && w_lut_valid_next;

  always_ff @(posedge AXI_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_mute_cnt  <= '0;
      r_err       <= 1'b0;
      r_lut_valid <= 1'b0;
      r_wdpd      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_word      <= w_word_next;
      r_mute_cnt  <= w_mute_cnt_next;
      r_err       <= w_err_next;
      r_lut_valid <= w_lut_valid_next;
      r_wdpd      <= w_wdpd_next;
    end
  end

  always_ff @(posedge AXI_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_coeff      <= '0;
      r_coeff_addr <= '0;
      r_coeff_en   <= 1'b0;
    end else begin
      r_coeff_en <= w_write;
      if (w_write) begin
        r_coeff      <= s_data_i;
        r_coeff_addr <= {r_word, 2'b00};
      end
    end
  end

  assign s_ready_o    = w_ready;
  assign coeff_o      = r_coeff;
  assign coeff_addr_o = r_coeff_addr;
  assign coeff_en_o   = r_coeff_en;
  assign wdpd_o       = r_wdpd;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);
  assign err_o        = r_err;

endmodule

// File: tb/tb_mp_lut_loader.sv
// Scoreboard bench for mp_lut_loader: sessions expected writes into a queue,
// a negedge monitor pops and compares every BRAM write.
module tb_mp_lut_loader;

  localparam int M      = 1;
  localparam int LUTN   = M + 1;
  localparam int RES    = 8;
  localparam int MUTE   = 4;
  localparam int ADDR_W = $clog2(RES) + $clog2(LUTN) + 2;
  localparam int N      = LUTN * RES;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic              abort_i;
  logic [31:0]       s_data_i;
  logic              s_valid_i;
  logic              s_last_i;
  logic              s_ready_o;
  logic [31:0]       coeff_o;
  logic [ADDR_W-1:0] coeff_addr_o;
  logic              coeff_en_o;
  logic              wdpd_req_i;
  logic              wdpd_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  mp_lut_loader #(
    .M(M), .LUT_num(LUTN), .RESOLUTION(RES), .MUTE_CYCLES(MUTE), .ADDR_W(ADDR_W)
  ) dut (
    .AXI_clk_i(clk), .reset_i(rst), .start_i(start_i), .abort_i(abort_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i),
    .s_ready_o(s_ready_o), .coeff_o(coeff_o), .coeff_addr_o(coeff_addr_o),
    .coeff_en_o(coeff_en_o), .wdpd_req_i(wdpd_req_i), .wdpd_o(wdpd_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  lut_valid_m = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && coeff_en_o) begin
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(coeff_addr_o), 64'(e.addr));
        chk("wr_data", 64'(coeff_o), 64'(e.data));
        $display("write addr=0x%02h data=0x%08h", coeff_addr_o, coeff_o);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ready"}, 64'(s_ready_o), 0);
    chk({tag, "_coeff"}, 64'(coeff_o), 0);
    chk({tag, "_addr"}, 64'(coeff_addr_o), 0);
    chk({tag, "_en"}, 64'(coeff_en_o), 0);
    chk({tag, "_wdpd"}, 64'(wdpd_o), 0);
    chk({tag, "_busy"}, 64'(busy_o), 0);
    chk({tag, "_done"}, 64'(done_o), 0);
    chk({tag, "_err"}, 64'(err_o), 0);
  endtask

  // last_at/abort_at/reset_at: word index where that event happens (-1 = never)
  task automatic run_session(input int last_at, input int abort_at, input int reset_at,
                             input int gap_pct, input bit fixed_data);
    int k, lo;
    bit fin, ok, ab, v;
    logic [31:0] d;
    wr_t e;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("busy_after_start", 64'(busy_o), 1);
    chk("wdpd_after_start", 64'(wdpd_o), 0);
    chk("err_cleared_by_start", 64'(err_o), 0);
    lut_valid_m = 1'b0;
    lo = 0;
    while (!s_ready_o && lo < 20) begin
      lo++;
      tick();
    end
    chk("mute_cycles", 64'(lo), 64'(MUTE));
    k = 0; fin = 0; ok = 0; ab = 0;
    while (!fin) begin
      v = ($urandom_range(99) >= gap_pct) || (k == reset_at);
      d = fixed_data ? 32'h100 + 32'(k) : $urandom;
      s_valid_i = v;
      s_data_i  = d;
      s_last_i  = (k == last_at);
      abort_i   = v && (k == abort_at);
      if (k == reset_at) begin
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk_all_zero("reset_mid_load");
        lut_valid_m = 1'b0;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        chk("reset_writes_drained", 64'(exp_q.size()), 0);
        tick();
        rst = 1'b0;
        tick();
        $display("session reset at word %0d", k);
        return;
      end
      tick();
      if (v) begin
        if (k == abort_at) begin
          ab = 1; fin = 1;
        end else begin
          e.addr = ADDR_W'(k * 4);
          e.data = d;
          exp_q.push_back(e);
          if (k == last_at || k == N - 1) begin
            ok  = (k == last_at) && (k == N - 1);
            fin = 1;
          end
        end
        k++;
      end
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    abort_i   = 1'b0;
    chk("done_pulse", 64'(done_o), 64'(ok));
    chk("err_flag", 64'(err_o), 64'(!ok));
    chk("busy_end", 64'(busy_o), 64'(!ab));
    chk("ready_after_last", 64'(s_ready_o), 0);
    tick();
    lut_valid_m = ok;
    chk("busy_idle", 64'(busy_o), 0);
    chk("done_single", 64'(done_o), 0);
    chk("err_hold", 64'(err_o), 64'(!ok));
    chk("wdpd_after", 64'(wdpd_o), 64'(wdpd_req_i && lut_valid_m));
    chk("writes_drained", 64'(exp_q.size()), 0);
    $display("session words=%0d ok=%0d abort=%0d err=%0d", k, ok, ab, err_o);
  endtask

  initial begin
    int kind;
    rst = 1'b1; start_i = 0; abort_i = 0; s_data_i = 0; s_valid_i = 0; s_last_i = 0;
    wdpd_req_i = 1'b1;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wdpd_no_load", 64'(wdpd_o), 0);
    end

    run_session(N - 1, -1, -1, 0, 1);          // directed full load
    wdpd_req_i = 1'b0; tick();
    chk("wdpd_req_low", 64'(wdpd_o), 0);
    wdpd_req_i = 1'b1; tick();
    chk("wdpd_req_high", 64'(wdpd_o), 1);
    run_session(N - 1, -1, -1, 40, 0);         // random valid gaps
    run_session(5, -1, -1, 0, 0);              // short frame
    run_session(N - 1, -1, -1, 20, 0);         // recovery clears err
    run_session(-1, -1, -1, 0, 0);             // long frame
    run_session(N - 1, 3, -1, 0, 0);           // abort on word 3 handshake

    start_i = 1'b1; abort_i = 1'b1; tick();
    start_i = 1'b0; abort_i = 1'b0;
    chk("start_with_abort_idle", 64'(busy_o), 0);
    tick();
    chk("start_with_abort_idle2", 64'(busy_o), 0);

    run_session(N - 1, -1, 10, 0, 0);          // reset mid-load at word 10
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wdpd_after_reset", 64'(wdpd_o), 0);
    end
    run_session(7, -1, -1, 0, 0);
    run_session(N - 1, -1, -1, 0, 0);

    for (int s = 0; s < 8; s++) begin
      kind = $urandom_range(3);
      case (kind)
        0: run_session(N - 1, -1, -1, $urandom_range(50), 0);
        1: run_session($urandom_range(N - 2), -1, -1, $urandom_range(50), 0);
        2: run_session(N - 1, $urandom_range(N - 1), -1, $urandom_range(50), 0);
        default: run_session(-1, -1, -1, $urandom_range(50), 0);
      endcase
      tick();
      chk("wdpd_idle", 64'(wdpd_o), 64'(lut_valid_m));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
